// File: rtl/fetch_decode_pkg.sv
// Shared types and constants for the fetch/decode slice: widths, opcode fields,
// ALU class encodings and the control-decode helper.
package fetch_decode_pkg;

  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_PASS  = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_t;

  // Which immediate field feeds sign_extended
  typedef enum logic [1:0] {
    IMM_NONE = 2'b00,
    IMM_D    = 2'b01,
    IMM_CB   = 2'b10,
    IMM_B    = 2'b11
  } imm_t;

  typedef struct packed {
    logic    uncond_branch;
    logic    branch;
    logic    mem_read;
    logic    mem_to_reg;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
    logic    reg2loc;
    alu_op_t alu_op;
    imm_t    imm;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [INSTR_LEN-1:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[31:21])
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        c.reg_write = 1'b1;
        c.alu_op    = ALU_RTYPE;
      end
      OP_LDUR: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.imm        = IMM_D;
      end
      OP_STUR: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.reg2loc   = 1'b1;
        c.imm       = IMM_D;
      end
      default: begin
        if (instr[31:24] == OP_CBZ) begin
          c.branch  = 1'b1;
          c.alu_op  = ALU_PASS;
          c.reg2loc = 1'b1;
          c.imm     = IMM_CB;
        end else if (instr[31:26] == OP_B) begin
          c.uncond_branch = 1'b1;
          c.alu_op        = ALU_PASS;
          c.imm           = IMM_B;
        end
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fetch_decode_regfile.sv
// 32 x WORD register file, two combinational read ports, one write port, X31 reads zero.
// REG_PRELOAD_EN: when defined, reset loads Xi = i instead of clearing.
module fetch_decode_regfile
  import fetch_decode_pkg::*;
#(
  parameter int WORD = fetch_decode_pkg::WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [WORD-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [WORD-1:0] rdata1,
  output logic [WORD-1:0] rdata2
);

  logic [WORD-1:0] regs [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
`ifdef REG_PRELOAD_EN
        regs[i] <= (i == 31) ? '0 : WORD'(i);
`else
        regs[i] <= '0;
`endif
      end
    end else if (we && waddr != 5'd31) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd31) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd31) ? '0 : regs[raddr2];

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode slice: PC register, loadable instruction memory, control decode,
// immediate sign extension and register file. REG_PRELOAD_EN selects regfile reset contents.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int WORD       = fetch_decode_pkg::WORD,
  parameter int INSTR_LEN  = fetch_decode_pkg::INSTR_LEN,
  parameter int IMEM_DEPTH = 64,
  localparam int AW        = $clog2(IMEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_src,
  input  logic [WORD-1:0]      branch_target,
  input  logic [WORD-1:0]      write_data,
  input  logic                 imem_we,
  input  logic [AW-1:0]        imem_addr,
  input  logic [INSTR_LEN-1:0] imem_wdata,
  output logic [WORD-1:0]      cur_pc,
  output logic [INSTR_LEN-1:0] instruction,
  output logic                 uncond_branch,
  output logic                 branch,
  output logic                 mem_read,
  output logic                 mem_to_reg,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic [1:0]           alu_op,
  output logic [WORD-1:0]      read_data1,
  output logic [WORD-1:0]      read_data2,
  output logic [WORD-1:0]      sign_extended
);

  logic [INSTR_LEN-1:0] imem [IMEM_DEPTH];
  ctrl_t                ctrl;

  function automatic logic signed [WORD-1:0] sext_d(input logic [8:0] f);
    return {{(WORD-9){f[8]}}, f};
  endfunction

  function automatic logic signed [WORD-1:0] sext_cb(input logic [18:0] f);
    return {{(WORD-19){f[18]}}, f};
  endfunction

  function automatic logic signed [WORD-1:0] sext_b(input logic [25:0] f);
    return {{(WORD-26){f[25]}}, f};
  endfunction

  // Fetch: PC register; reset wins over any pending update on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_pc <= '0;
    else       cur_pc <= pc_src ? branch_target : cur_pc + WORD'(4);
  end

  // Instruction memory keeps its contents and stays writable through reset
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
  end

  assign instruction = imem[cur_pc[AW+1:2]];

  // Decode
  assign ctrl          = decode_ctrl(instruction);
  assign uncond_branch = ctrl.uncond_branch;
  assign branch        = ctrl.branch;
  assign mem_read      = ctrl.mem_read;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign mem_write     = ctrl.mem_write;
  assign alu_src       = ctrl.alu_src;
  assign reg_write     = ctrl.reg_write;
  assign alu_op        = ctrl.alu_op;

  always_comb begin
    sign_extended = '0;
    case (ctrl.imm)
      IMM_D:   sign_extended = sext_d(instruction[20:12]);
      IMM_CB:  sign_extended = sext_cb(instruction[23:5]);
      IMM_B:   sign_extended = sext_b(instruction[25:0]);
      default: sign_extended = '0;
    endcase
  end

  fetch_decode_regfile #(.WORD(WORD)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (ctrl.reg_write),
    .waddr  (instruction[4:0]),
    .wdata  (write_data),
    .raddr1 (instruction[9:5]),
    .raddr2 (ctrl.reg2loc ? instruction[4:0] : instruction[20:16]),
    .rdata1 (read_data1),
    .rdata2 (read_data2)
  );

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: PC sequencing, branch/wrap, async reset, decode and regfile.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_src;
  logic [63:0] branch_target;
  logic [63:0] write_data;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [63:0] cur_pc;
  logic [31:0] instruction;
  logic        uncond_branch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]  alu_op;
  logic [63:0] read_data1, read_data2, sign_extended;

  int nvec  = 0;
  int nfail = 0;

`ifdef REG_PRELOAD_EN
  localparam logic [63:0] EXP_X5_RST = 64'd5;
  localparam logic [63:0] EXP_X7_RST = 64'd7;
`else
  localparam logic [63:0] EXP_X5_RST = 64'd0;
  localparam logic [63:0] EXP_X7_RST = 64'd0;
`endif

  // {uncond, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
  localparam logic [8:0] C_RTYPE = 9'b000000110;
  localparam logic [8:0] C_LDUR  = 9'b001101100;
  localparam logic [8:0] C_CBZ   = 9'b010000001;
  localparam logic [8:0] C_B     = 9'b100000001;
  localparam logic [8:0] C_NONE  = 9'b000000000;

  localparam logic [31:0] I0  = 32'h8B1F03E1; // ADD X1,XZR,XZR
  localparam logic [31:0] I1  = 32'h8B1F03E2; // ADD X2
  localparam logic [31:0] I2  = 32'h8B1F03E3; // ADD X3
  localparam logic [31:0] I3  = 32'hF8408022; // LDUR X2,[X1,#8]
  localparam logic [31:0] I4  = 32'hB4FFFFC3; // CBZ X3,-2
  localparam logic [31:0] I5  = 32'h8B020025; // ADD X5,X1,X2
  localparam logic [31:0] I6  = 32'h8B1F03FF; // ADD X31
  localparam logic [31:0] I7  = 32'h00000000; // unknown
  localparam logic [31:0] I8  = 32'h8B1F00A7; // ADD X7,X5,XZR
  localparam logic [31:0] I9  = 32'h14000003; // B +3
  localparam logic [31:0] I16 = 32'hD503201F; // unknown
  localparam logic [31:0] I63 = 32'hAA000063; // unknown
  localparam logic [31:0] IR  = 32'h8B0500E9; // ADD X9,X7,X5

  logic [8:0] ctrl;
  assign ctrl = {uncond_branch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op};

  fetch_decode dut (
    .clk           (clk),
    .reset         (reset),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .write_data    (write_data),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .cur_pc        (cur_pc),
    .instruction   (instruction),
    .uncond_branch (uncond_branch),
    .branch        (branch),
    .mem_read      (mem_read),
    .mem_to_reg    (mem_to_reg),
    .mem_write     (mem_write),
    .alu_src       (alu_src),
    .reg_write     (reg_write),
    .alu_op        (alu_op),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .sign_extended (sign_extended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] w);
    imem_we    = 1'b1;
    imem_addr  = a;
    imem_wdata = w;
    tick();
    imem_we    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc_src = 1'b0; branch_target = '0; write_data = '0;
    imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;

    load(6'd0, I0);  load(6'd1, I1);  load(6'd2, I2);  load(6'd3, I3);
    load(6'd4, I4);  load(6'd5, I5);  load(6'd6, I6);  load(6'd7, I7);
    load(6'd8, I8);  load(6'd9, I9);  load(6'd16, I16); load(6'd63, I63);

    chk("rst_pc", cur_pc, 64'd0);
    chk("rst_instr", {32'd0, instruction}, {32'd0, I0});

    reset = 1'b0; write_data = 64'd1; #1;
    chk("pc0", cur_pc, 64'd0);
    chk("ctrl_add_x1", {55'd0, ctrl}, {55'd0, C_RTYPE});

    tick(); write_data = 64'd2; #1;
    chk("pc4", cur_pc, 64'd4);
    chk("instr1", {32'd0, instruction}, {32'd0, I1});

    tick(); write_data = 64'd3; #1;
    chk("pc8", cur_pc, 64'd8);
    chk("instr2", {32'd0, instruction}, {32'd0, I2});

    tick(); write_data = 64'd2; #1;
    chk("pc12", cur_pc, 64'd12);
    chk("instr3", {32'd0, instruction}, {32'd0, I3});
    chk("ldur_ctrl", {55'd0, ctrl}, {55'd0, C_LDUR});
    chk("ldur_sext", sign_extended, 64'd8);
    chk("ldur_rd1", read_data1, 64'd1);

    tick(); #1;
    chk("cbz_ctrl", {55'd0, ctrl}, {55'd0, C_CBZ});
    chk("cbz_sext", sign_extended, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("cbz_rd2", read_data2, 64'd3);

    tick(); write_data = 64'h1234; #1;
    chk("add_ctrl", {55'd0, ctrl}, {55'd0, C_RTYPE});
    chk("add_rd1", read_data1, 64'd1);
    chk("add_rd2", read_data2, 64'd2);
    chk("add_sext", sign_extended, 64'd0);

    tick(); write_data = 64'hFFFF; #1;
    chk("x31_instr", {32'd0, instruction}, {32'd0, I6});

    tick(); #1;
    chk("zero_op_ctrl", {55'd0, ctrl}, {55'd0, C_NONE});
    chk("zero_op_sext", sign_extended, 64'd0);

    tick(); write_data = 64'h77; #1;
    chk("x5_written", read_data1, 64'h1234);
    chk("x31_reads0", read_data2, 64'd0);

    tick(); #1;
    chk("b_ctrl", {55'd0, ctrl}, {55'd0, C_B});
    chk("b_sext", sign_extended, 64'd3);

    pc_src = 1'b1; branch_target = 64'h40;
    tick(); #1;
    chk("br_pc", cur_pc, 64'h40);
    chk("br_instr", {32'd0, instruction}, {32'd0, I16});
    chk("br_ctrl", {55'd0, ctrl}, {55'd0, C_NONE});

    branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(); pc_src = 1'b0; #1;
    chk("top_pc", cur_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("top_instr", {32'd0, instruction}, {32'd0, I63});

    tick(); write_data = 64'h999; #1;
    chk("wrap_pc", cur_pc, 64'd0);
    chk("wrap_instr", {32'd0, instruction}, {32'd0, I0});

    tick(); #1;
    chk("pre_rst_pc", cur_pc, 64'd4);
    reset = 1'b1; #1;
    chk("async_rst_pc", cur_pc, 64'd0);

    load(6'd0, IR);
    chk("held_rst_pc", cur_pc, 64'd0);
    reset = 1'b0; #1;
    chk("imem_wr_in_rst", {32'd0, instruction}, {32'd0, IR});
    chk("rst_x7", read_data1, EXP_X7_RST);
    chk("rst_x5", read_data2, EXP_X5_RST);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameters: WORD=64, data width; INSTR_LEN=32, instruction width; IMEM_DEPTH=64, instruction words.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 pc_src  in  1  1 selects branch_target as next PC.
REQ-005 branch_target  in  WORD  branch destination byte address.
REQ-006 write_data  in  WORD  write-back value for Rd.
REQ-007 imem_we / imem_addr / imem_wdata  in  1 / log2(IMEM_DEPTH) / INSTR_LEN  instruction-memory load port.
REQ-008 cur_pc  out  WORD  current PC; instruction  out  INSTR_LEN  imem word at cur_pc.
REQ-009 uncond_branch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  control signals.
REQ-010 alu_op  out  2  ALU class; read_data1, read_data2, sign_extended  out  WORD each.

Function
REQ-011 PC: next = pc_src ? branch_target : cur_pc+4, 64-bit wrap; instruction = imem[cur_pc[log2(IMEM_DEPTH)+1:2]], combinational, index wraps modulo depth.
REQ-012 imem written synchronously when imem_we=1, including during reset; never cleared by reset.
REQ-013 Control decode on instruction[31:21], combinational: R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> reg_write=1, alu_op=10, rest 0.
REQ-014 LDUR 11111000010 -> alu_src, mem_to_reg, reg_write, mem_read = 1; alu_op=00.
REQ-015 STUR 11111000000 -> alu_src, mem_write = 1; alu_op=00; reg2loc=1.
REQ-016 CBZ [31:24]=10110100 -> branch=1, alu_op=01, reg2loc=1; B [31:26]=000101 -> uncond_branch=1, alu_op=01.
REQ-017 Any other opcode -> all control outputs 0, alu_op=00.
REQ-018 Register file 32 x WORD; read_data1 = X[[9:5]]; read_data2 = X[reg2loc ? [4:0] : [20:16]]; combinational reads.
REQ-019 X31 reads 0 always; writes to X31 ignored.
REQ-020 Write: on rising clk with reg_write=1 and reset=0, X[[4:0]] <= write_data; reads show old value until that edge.
REQ-021 sign_extended: LDUR/STUR sext([20:12]); CBZ sext([23:5]); B sext([25:0]); otherwise 0.

Reset
REQ-022 reset=1 forces cur_pc=0 immediately; registers X0-X30 cleared (see REQ-024); outputs then follow imem[0] decode.
REQ-023 Reset mid-operation discards pending PC update and register write on that edge.

Configuration
REQ-024 Macro REG_PRELOAD_EN: defined -> reset loads Xi=i for i=0..30; undefined -> reset loads all registers 0.

Structure
REQ-025 Shared package holds WORD, INSTR_LEN, opcode constants, alu_op encodings (00 add, 01 pass/zero-test, 10 R-type func).
REQ-026 One sub-module: regfile (32 x WORD, 2 read ports, 1 write port, X31 hardwired zero).

Verification
REQ-027 Assert reset, release, 3 edges with pc_src=0 -> cur_pc 0,4,8,12; instruction tracks imem[0..3].
REQ-028 pc_src=1, branch_target=0x40 -> after edge cur_pc=0x40, instruction=imem[16]; reset asserted between edges -> cur_pc=0 without waiting for clk.
REQ-029 Instruction 0xF8408022 (LDUR X2,[X1,#8]), REG_PRELOAD_EN -> mem_read=mem_to_reg=alu_src=reg_write=1, alu_op=00, sign_extended=8, read_data1=1.
REQ-030 Instruction 0xB4FFFFC3 (CBZ X3,-2), REG_PRELOAD_EN -> branch=1, alu_op=01, sign_extended=0xFFFFFFFFFFFFFFFE, read_data2=3, reg_write=0.
REQ-031 Instruction 0x8B020025 (ADD X5,X1,X2), write_data=0x1234 -> before edge read_data1=1, read_data2=2; after edge X5 reads 0x1234.
REQ-032 Rd=31 with reg_write=1, write_data=0xFFFF -> X31 still reads 0; unknown opcode 0x00000000 -> all controls 0.
